conv_engine: RTL and testbench
==============================

Name: conv_engine

Overview:
- Parametrised serial 1-D linear convolution engine, successor to the fixed 8x8 4-bit convolver in the hw2 datapath.
- Loads two LEN-sample sequences f and g over a single input stream, then computes y[k] = sum f[i]*g[k-i] for k = 0..2*LEN-2 with one shared multiplier.
- Streams results out under a valid/ready handshake.
- New versus the previous generation: configurable length and width, a signed/unsigned mode, gap-tolerant input, output backpressure, and a last-sample flag.

Parameters:
- LEN, 8, samples per input sequence (2..64).
- DW, 4, input sample width in bits.
- OW, 2*DW+$clog2(LEN), output width; full precision, so no overflow in either mode.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Din  in  DW  input sample.
- in_en  in  1  Din valid; a sample is accepted when in_en=1 and busy=0.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the first accepted sample of a frame.
- busy  out  1  0 = engine accepts input.
- out_valid  out  1  Dout holds a valid result.
- out_ready  in  1  downstream accepts Dout.
- Dout  out  OW  convolution result y[k].
- dout_last  out  1  asserted with out_valid for k = 2*LEN-2.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, busy=1, out_valid=0, Dout=0, dout_last=0;
  - all counters and the accumulator to 0;
  - f/g storage to 0.
- Reset may assert at any time, including mid-CALC or mid-OUT. The frame in progress is discarded and no partial output appears.
- IDLE: busy=1 for exactly one cycle after reset release, then go to LOAD.
- LOAD (busy=0):
  - Each accepted sample is written to f[cnt] for cnt<LEN, otherwise to g[cnt-LEN]; cnt then increments.
  - Gaps (in_en=0) hold cnt; they do not restart the frame.
  - sgn is latched into mode_r when cnt=0 is accepted.
  - On acceptance of sample 2*LEN-1, busy=1 in the next cycle and state goes to CALC with k=0, acc=0.
  - in_en while busy=1 is ignored.
- CALC (busy=1):
  - Term range: i runs from lo = max(0, k-LEN+1) to hi = min(k, LEN-1).
  - One term per cycle: acc <= acc + f[i]*g[k-i].
  - Product and sum use mode_r: sign-extend operands when signed, zero-extend when unsigned, to OW bits.
  - After the hi term, Dout <= final sum and out_valid <= 1; dout_last <= (k == 2*LEN-2); state goes to OUT.
  - Latency from CALC entry to out_valid for y[k] is (hi-lo+1) cycles.
- OUT:
  - Dout, out_valid and dout_last hold stable until out_ready=1.
  - On the handshake cycle (out_valid & out_ready), next cycle out_valid=0 and dout_last=0. Dout keeps its last value.
  - If k < 2*LEN-2: k++, acc=0, back to CALC.
  - Otherwise go to LOAD with cnt=0 and busy=0 in that cycle.
  - out_ready while out_valid=0 has no effect.
- Frame totals:
  - Exactly 2*LEN-1 output handshakes per frame, in increasing k order.
  - Exactly one dout_last per frame.
- Back-to-back frames need no idle cycle; the next frame's first sample may be accepted in the first LOAD cycle.
- A single state enum covers {IDLE, LOAD, CALC, OUT}. All four are reachable; there are no other encodings.

Decomposition:
- conv_pkg holds:
  - state enum (IDLE, LOAD, CALC, OUT);
  - localparam helpers for OW and counter widths ($clog2(2*LEN), $clog2(2*LEN-1));
  - functions lo_idx(k) and hi_idx(k).
- One sub-module, conv_mac: registered multiply-accumulate.
  - Inputs: a[DW], b[DW], signed_mode, clear, en.
  - Output: acc[OW].
  - conv_engine instantiates one conv_mac. The FSM, storage and handshake stay in conv_engine.

Test Plan:
- Unsigned ramp (LEN=8, DW=4, sgn=0, f=g=all 1, continuous in_en, out_ready=1):
  - Dout = 1,2,3,4,5,6,7,8,7,6,5,4,3,2,1;
  - dout_last only with the final 1;
  - busy=0 again after the 15th handshake.
- Unsigned max (f=g=all 15): y[7]=1800, y[0]=225, y[14]=225; no truncation in OW=11 bits.
- Signed extremes (sgn=1):
  - f=g=all 4'h8 (-8): y[7]=512 and y[0]=64.
  - Next frame f=all -8, g=all 7: y[7]=-448 (11'h640) and y[0]=-56.
  - mode_r latched per frame.
- Input gaps and backpressure:
  - in_en toggling 1/0 while loading f=1..8, g=all 1: y[0]=1, y[7]=36, y[14]=8.
  - out_ready held 0 for 5 cycles on y[3]: Dout=10 stays stable with out_valid=1 throughout; no result is skipped or duplicated.
- Busy discipline: in_en=1 with garbage Din during CALC/OUT is ignored; the next frame's results are unaffected.
- Reset mid-CALC (assert reset during y[5] accumulation):
  - busy=1, out_valid=0 and Dout=0 immediately, without waiting for a clock edge;
  - after release, one IDLE cycle then busy=0;
  - a fresh ones frame yields the correct 1..8..1 sequence.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the serial 1-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  localparam int LEN_DEF = 8;
  localparam int DW_DEF  = 4;

  // Full-precision output width: product of two DW samples plus growth from LEN terms.
  function automatic int ow_calc(input int len, input int dw);
    return 2*dw + $clog2(len);
  endfunction

  // Load counter spans 0..2*LEN-1.
  function automatic int cnt_w(input int len);
    return $clog2(2*len);
  endfunction

  // Output index k spans 0..2*LEN-2.
  function automatic int k_w(input int len);
    return $clog2(2*len-1);
  endfunction

  // Term index i spans 0..LEN-1.
  function automatic int idx_w(input int len);
    return $clog2(len);
  endfunction

  // First f index that contributes to y[k].
  function automatic int lo_idx(input int k, input int len);
    return (k >= len) ? (k - len + 1) : 0;
  endfunction

  // Last f index that contributes to y[k].
  function automatic int hi_idx(input int k, input int len);
    return (k < len) ? k : (len - 1);
  endfunction

endpackage

// File: rtl/conv_engine_if.sv
// Sample-in / result-out handshake bundle of conv_engine.
interface conv_engine_if #(
  parameter int DW = 4,
  parameter int OW = 11
);
  logic [DW-1:0] Din;
  logic          in_en;
  logic          sgn;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] Dout;
  logic          dout_last;

  modport slave (
    input  Din, in_en, sgn, out_ready,
    output busy, out_valid, Dout, dout_last
  );

  modport master (
    output Din, in_en, sgn, out_ready,
    input  busy, out_valid, Dout, dout_last
  );
endinterface

// File: rtl/conv_mac.sv
// Registered multiply-accumulate. The acc output is the running total that
// includes the current term, so the caller can capture a finished sum on the
// same edge that the last term is accumulated.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = ow_calc(LEN_DEF, DW_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          signed_mode,
  input  logic          clear,
  input  logic          en,
  output logic [OW-1:0] acc
);
  logic [OW-1:0] a_x, b_x, prod, acc_q;

  // Extend operands to full width; low OW bits of the product are exact in both modes.
  always_comb begin
    a_x  = signed_mode ? {{(OW-DW){a[DW-1]}}, a} : {{(OW-DW){1'b0}}, a};
    b_x  = signed_mode ? {{(OW-DW){b[DW-1]}}, b} : {{(OW-DW){1'b0}}, b};
    prod = a_x * b_x;
  end

  assign acc = acc_q + prod;

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clear) acc_q <= '0;
    else if (en)    acc_q <= acc;
  end
endmodule

// File: rtl/conv_engine.sv
// Serial 1-D linear convolution: loads f then g (LEN samples each) from one
// stream, computes y[k] = sum f[i]*g[k-i] one term per cycle with a single
// MAC, and streams the 2*LEN-1 results out under valid/ready.
module conv_engine
  import conv_pkg::*;
#(
  parameter int LEN = LEN_DEF,
  parameter int DW  = DW_DEF,
  parameter int OW  = ow_calc(LEN, DW)
) (
  input  logic          clk,
  input  logic          reset,
  conv_engine_if.slave  io
);
  localparam int CW = cnt_w(LEN);
  localparam int KW = k_w(LEN);
  localparam int IW = idx_w(LEN);
  localparam logic [KW-1:0] K_LAST = KW'(2*LEN-2);
  localparam logic [CW-1:0] C_LAST = CW'(2*LEN-1);

  state_t state, state_n;

  logic [LEN-1:0][DW-1:0] f_mem, g_mem;
  logic [CW-1:0] cnt, g_wr;
  logic [KW-1:0] k, g_rd_k;
  logic [IW-1:0] i, hi, lo_nxt, g_rd;
  logic          mode_r;
  logic          accept, hs;
  logic [OW-1:0] acc;
  logic [OW-1:0] dout_r;
  logic          out_valid_r, dout_last_r;

  assign io.busy      = (state != LOAD);
  assign io.out_valid = out_valid_r;
  assign io.Dout      = dout_r;
  assign io.dout_last = dout_last_r;

  assign accept = (state == LOAD) && io.in_en;
  assign hs     = (state == OUT) && out_valid_r && io.out_ready;
  assign hi     = IW'(hi_idx(int'(k), LEN));
  assign lo_nxt = IW'(lo_idx(int'(k) + 1, LEN));
  assign g_wr   = cnt - CW'(LEN);
  assign g_rd_k = k - KW'(i);
  assign g_rd   = g_rd_k[IW-1:0];

  // Single shared MAC; held clear outside CALC so every y[k] starts from zero.
  conv_mac #(.DW(DW), .OW(OW)) u_mac (
    .clk         (clk),
    .rst_n       (reset),
    .a           (f_mem[i]),
    .b           (g_mem[g_rd]),
    .signed_mode (mode_r),
    .clear       (state != CALC),
    .en          (state == CALC),
    .acc         (acc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = LOAD;
      LOAD: if (accept && cnt == C_LAST) state_n = CALC;
      CALC: if (i == hi) state_n = OUT;
      OUT:  if (hs) state_n = (k == K_LAST) ? LOAD : CALC;
      default: state_n = IDLE;
    endcase
  end

  // Sample storage, counters and result/handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_mem       <= '0;
      g_mem       <= '0;
      cnt         <= '0;
      k           <= '0;
      i           <= '0;
      mode_r      <= 1'b0;
      dout_r      <= '0;
      out_valid_r <= 1'b0;
      dout_last_r <= 1'b0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          if (cnt == '0) mode_r <= io.sgn;
          if (cnt < CW'(LEN)) f_mem[cnt[IW-1:0]] <= io.Din;
          else                g_mem[g_wr[IW-1:0]] <= io.Din;
          if (cnt == C_LAST) begin
            cnt <= '0;
            k   <= '0;
            i   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CALC: begin
          if (i == hi) begin
            dout_r      <= acc;
            out_valid_r <= 1'b1;
            dout_last_r <= (k == K_LAST);
          end else begin
            i <= i + IW'(1);
          end
        end
        OUT: if (hs) begin
          out_valid_r <= 1'b0;
          dout_last_r <= 1'b0;
          if (k != K_LAST) begin
            k <= k + KW'(1);
            i <= lo_nxt;
          end else begin
            k <= '0;
            i <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_engine.sv
// Randomised self-checking bench for conv_engine against a direct
// sum-of-products reference model.
module tb_conv_engine;
  import conv_pkg::*;

  localparam int LEN = 8;
  localparam int DW  = 4;
  localparam int OW  = 11;
  localparam int NY  = 2*LEN-1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_engine_if #(.DW(DW), .OW(OW)) io ();

  conv_engine #(.LEN(LEN), .DW(DW), .OW(OW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (io)
  );

  int total  = 0;
  int passed = 0;

  int            fa [LEN];
  int            ga [LEN];
  logic [OW-1:0] exp_y [NY];
  logic [OW-1:0] got   [NY];

  function automatic int sval(input int v, input bit s);
    return (s && v >= (1 << (DW-1))) ? v - (1 << DW) : v;
  endfunction

  task automatic compute_model(input bit s);
    for (int kk = 0; kk < NY; kk++) begin
      int sum = 0;
      for (int ii = 0; ii < LEN; ii++) begin
        int jj = kk - ii;
        if (jj >= 0 && jj < LEN) sum += sval(fa[ii], s) * sval(ga[jj], s);
      end
      exp_y[kk] = OW'(sum);
    end
  endtask

  // Load one frame, then collect n_hs results and compare each to the model.
  task automatic run_frame(input bit s, input bit flip_sgn, input bit gaps,
                           input bit rnd_ready, input int stall_k,
                           input bit garbage, input int n_hs);
    int idx, cyc, kk, stall;
    bit b, rdy, tgl;
    compute_model(s);
    idx = 0; cyc = 0; tgl = 1'b0;
    while (idx < 2*LEN && cyc < 500) begin
      @(negedge clk); cyc++;
      b   = io.busy;
      tgl = gaps ? ~tgl : 1'b1;
      if (tgl) begin
        io.in_en = 1'b1;
        io.Din   = DW'(idx < LEN ? fa[idx] : ga[idx-LEN]);
        io.sgn   = (flip_sgn && idx > 0) ? ~s : s;
        if (!b) idx++;
      end else begin
        io.in_en = 1'b0;
        io.Din   = DW'($urandom);
        io.sgn   = 1'($urandom);
      end
    end
    total++;
    if (idx != 2*LEN) $display("FAIL load_timeout: accepted %0d, want %0d", idx, 2*LEN);
    else passed++;

    kk = 0; stall = 0; cyc = 0;
    while (kk < n_hs && cyc < 2000) begin
      @(negedge clk); cyc++;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (io.out_valid && kk == stall_k && stall < 5) begin
        rdy = 1'b0; stall++;
        total++;
        if (io.Dout !== exp_y[kk])
          $display("FAIL stall_hold k=%0d: Dout=%0d, want %0d", kk, io.Dout, exp_y[kk]);
        else passed++;
      end
      if (io.out_valid && rdy) begin
        total++;
        if (io.Dout !== exp_y[kk])
          $display("FAIL dout k=%0d: got %0h, want %0h", kk, io.Dout, exp_y[kk]);
        else passed++;
        total++;
        if (io.dout_last !== (kk == NY-1))
          $display("FAIL dout_last k=%0d: got %b, want %b", kk, io.dout_last, kk == NY-1);
        else passed++;
        got[kk] = io.Dout;
        kk++;
      end else if (!io.out_valid) begin
        total++;
        if (io.dout_last !== 1'b0) $display("FAIL last_without_valid: got %b, want 0", io.dout_last);
        else passed++;
      end
      io.out_ready = rdy;
      io.in_en     = garbage && !(io.out_valid && rdy && kk == NY);
      io.Din       = DW'($urandom);
      io.sgn       = 1'($urandom);
    end
    total++;
    if (kk != n_hs) $display("FAIL out_timeout: handshakes %0d, want %0d", kk, n_hs);
    else passed++;

    if (n_hs == NY) begin
      @(negedge clk);
      io.in_en = 1'b0;
      total++;
      if (io.busy !== 1'b0 || io.out_valid !== 1'b0 || io.dout_last !== 1'b0)
        $display("FAIL frame_end: busy=%b out_valid=%b last=%b, want 0 0 0",
                 io.busy, io.out_valid, io.dout_last);
      else passed++;
    end
  endtask

  task automatic fill(input int fv, input int gv);
    for (int n = 0; n < LEN; n++) begin fa[n] = fv; ga[n] = gv; end
  endtask

  task automatic spot(input string name, input logic [OW-1:0] act, input logic [OW-1:0] want);
    total++;
    if (act !== want) $display("FAIL %s: got %0h, want %0h", name, act, want);
    else passed++;
  endtask

  task automatic test_reset();
    io.in_en = 1'b0; io.Din = '0; io.sgn = 1'b0; io.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (io.busy !== 1'b1 || io.out_valid !== 1'b0 || io.Dout !== '0 || io.dout_last !== 1'b0)
      $display("FAIL reset_state: busy=%b valid=%b Dout=%0h last=%b, want 1 0 0 0",
               io.busy, io.out_valid, io.Dout, io.dout_last);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (io.busy !== 1'b1) $display("FAIL idle_busy: got %b, want 1", io.busy);
    else passed++;
    @(negedge clk);
    total++;
    if (io.busy !== 1'b0) $display("FAIL load_after_idle: busy=%b, want 0", io.busy);
    else passed++;
  endtask

  task automatic test_unsigned_ramp();
    fill(1, 1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("ramp_y0", got[0], 11'd1);
    spot("ramp_y7", got[7], 11'd8);
    spot("ramp_y14", got[14], 11'd1);
  endtask

  task automatic test_unsigned_max();
    fill(15, 15);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("max_y7", got[7], 11'd1800);
    spot("max_y0", got[0], 11'd225);
    spot("max_y14", got[14], 11'd225);
  endtask

  task automatic test_signed_extremes();
    fill(8, 8);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("sneg_y7", got[7], 11'd512);
    spot("sneg_y0", got[0], 11'd64);
    fill(8, 7);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("smix_y7", got[7], 11'h640);
    spot("smix_y0", got[0], 11'h7C8);
    // sgn changes after the first sample; the frame stays signed
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("latch_y7", got[7], 11'h640);
    // same data unsigned in the following frame
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("uns_y7", got[7], 11'd448);
  endtask

  task automatic test_gaps_backpressure();
    for (int n = 0; n < LEN; n++) begin fa[n] = n + 1; ga[n] = 1; end
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0, NY);
    spot("gap_y0", got[0], 11'd1);
    spot("gap_y3", got[3], 11'd10);
    spot("gap_y7", got[7], 11'd36);
    spot("gap_y14", got[14], 11'd8);
  endtask

  task automatic test_busy_garbage();
    for (int n = 0; n < LEN; n++) begin fa[n] = $urandom_range(0, 15); ga[n] = $urandom_range(0, 15); end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1, NY);
    fill(1, 1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("after_garbage_y7", got[7], 11'd8);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < LEN; n++) begin fa[n] = $urandom_range(0, 15); ga[n] = $urandom_range(0, 15); end
      run_frame(1'($urandom), 1'b0, 1'($urandom), 1'b1, -1, 1'($urandom), NY);
    end
  endtask

  task automatic test_reset_mid_calc();
    fill(1, 1);
    io.out_ready = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 5);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    io.in_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (io.busy !== 1'b1 || io.out_valid !== 1'b0 || io.Dout !== '0)
      $display("FAIL async_reset: busy=%b valid=%b Dout=%0h, want 1 0 0",
               io.busy, io.out_valid, io.Dout);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (io.busy !== 1'b1) $display("FAIL idle_after_midreset: busy=%b, want 1", io.busy);
    else passed++;
    @(negedge clk);
    total++;
    if (io.busy !== 1'b0) $display("FAIL load_after_midreset: busy=%b, want 0", io.busy);
    else passed++;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, NY);
    spot("post_reset_y5", got[5], 11'd6);
    spot("post_reset_y14", got[14], 11'd1);
  endtask

  initial begin
    test_reset();
    test_unsigned_ramp();
    test_unsigned_max();
    test_signed_extremes();
    test_gaps_backpressure();
    test_busy_garbage();
    test_random();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
